// File: rtl/eth_xcvr_reset_pkg.sv
// Shared definitions for the transceiver reset sequencer: TX and RX FSM
// state encodings used by the per-channel sequencer.
package eth_xcvr_reset_pkg;

    typedef logic [2:0] state_t;

    // TX FSM states
    localparam state_t T_ARST  = 3'd0;  // analog + digital reset asserted
    localparam state_t T_WAIT  = 3'd1;  // analog released, waiting for PLL/cal
    localparam state_t T_DRST  = 3'd2;  // digital reset hold timer running
    localparam state_t T_REL   = 3'd3;  // digital released, waiting for ack
    localparam state_t T_READY = 3'd4;  // TX operational

    // RX FSM states
    localparam state_t R_ARST  = 3'd0;  // analog + digital reset asserted
    localparam state_t R_WAIT  = 3'd1;  // analog released, counting CDR lock
    localparam state_t R_REL   = 3'd2;  // digital released, waiting for ack
    localparam state_t R_READY = 3'd3;  // RX operational

endpackage

// File: rtl/eth_xcvr_reset_chan.sv
// Single-channel reset sequencer: one TX FSM and one RX FSM, each with its
// own saturating timer. Outputs are decoded from the state registers only.
module eth_xcvr_reset_chan
    import eth_xcvr_reset_pkg::*;
#(
    parameter int ANALOG_CYCLES  = 100,
    parameter int DIGITAL_CYCLES = 100,
    parameter int LOCK_CYCLES    = 1000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked_i,
    input  logic pll_cal_busy_i,
    input  logic tx_cal_busy_i,
    input  logic rx_cal_busy_i,
    input  logic tx_analogreset_stat_i,
    input  logic tx_digitalreset_stat_i,
    input  logic rx_analogreset_stat_i,
    input  logic rx_digitalreset_stat_i,
    input  logic rx_is_lockedtodata_i,
    input  logic rx_restart_i,
    output logic tx_analogreset_o,
    output logic tx_digitalreset_o,
    output logic rx_analogreset_o,
    output logic rx_digitalreset_o,
    output logic tx_ready_o,
    output logic rx_ready_o
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_ONE = cnt_t'(1);
    // Analog reset leaves once the timer has reached the limit (limit+1 cycles held).
    localparam cnt_t ANALOG_LIMIT  = cnt_t'(ANALOG_CYCLES);
    // The timer reads 0 in the first cycle of T_DRST, so the hold is complete at limit-1.
    localparam cnt_t DIGITAL_LIMIT = cnt_t'(DIGITAL_CYCLES - 1);
    localparam cnt_t LOCK_LIMIT    = cnt_t'(LOCK_CYCLES);

    state_t tx_state_q, tx_state_d;
    state_t rx_state_q, rx_state_d;
    cnt_t   tx_timer_q, tx_timer_d;
    cnt_t   rx_timer_q, rx_timer_d;

    logic   tx_cond_ok;
    logic   rx_cond_ok;
    cnt_t   tx_timer_inc;
    cnt_t   rx_timer_inc;

    // Conditions that allow TX digital reset release / RX lock counting.
    assign tx_cond_ok = pll_locked_i && !pll_cal_busy_i && !tx_cal_busy_i
                        && !tx_analogreset_stat_i;
    assign rx_cond_ok = rx_is_lockedtodata_i && !rx_cal_busy_i
                        && !rx_analogreset_stat_i;

    // Timers stick at all-ones instead of wrapping.
    assign tx_timer_inc = (tx_timer_q == CNT_MAX) ? tx_timer_q : tx_timer_q + CNT_ONE;
    assign rx_timer_inc = (rx_timer_q == CNT_MAX) ? rx_timer_q : rx_timer_q + CNT_ONE;

    // State and timer registers for both directions.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= T_ARST;
            rx_state_q <= R_ARST;
            tx_timer_q <= '0;
            rx_timer_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_timer_q <= tx_timer_d;
            rx_timer_q <= rx_timer_d;
        end
    end

    // TX next-state and timer logic.
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_inc;
        unique case (tx_state_q)
            T_ARST: begin
                if (tx_timer_q >= ANALOG_LIMIT && tx_analogreset_stat_i)
                    tx_state_d = T_WAIT;
            end
            T_WAIT: begin
                if (tx_cond_ok)
                    tx_state_d = T_DRST;
            end
            T_DRST: begin
                if (!tx_cond_ok)
                    tx_state_d = T_WAIT;
                else if (tx_timer_q >= DIGITAL_LIMIT)
                    tx_state_d = T_REL;
            end
            T_REL: begin
                if (!tx_digitalreset_stat_i)
                    tx_state_d = T_READY;
            end
            T_READY: begin
                if (!pll_locked_i)
                    tx_state_d = T_WAIT;
            end
            default: tx_state_d = T_ARST;
        endcase
        if (tx_state_d != tx_state_q)
            tx_timer_d = '0;
    end

    // RX next-state and timer logic; restart overrides every other transition.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_inc;
        unique case (rx_state_q)
            R_ARST: begin
                if (rx_timer_q >= ANALOG_LIMIT && rx_analogreset_stat_i)
                    rx_state_d = R_WAIT;
            end
            R_WAIT: begin
                // The timer counts consecutive good cycles; a bad cycle starts over.
                if (!rx_cond_ok)
                    rx_timer_d = '0;
                else if (rx_timer_q >= LOCK_LIMIT)
                    rx_state_d = R_REL;
            end
            R_REL: begin
                // Lock loss wins over the ack in the same cycle.
                if (!rx_is_lockedtodata_i)
                    rx_state_d = R_WAIT;
                else if (!rx_digitalreset_stat_i)
                    rx_state_d = R_READY;
            end
            R_READY: begin
                if (!rx_is_lockedtodata_i)
                    rx_state_d = R_WAIT;
            end
            default: rx_state_d = R_ARST;
        endcase
        if (rx_restart_i)
            rx_state_d = R_ARST;
        if (rx_state_d != rx_state_q || rx_restart_i)
            rx_timer_d = '0;
    end

    // TX output decode from the state register.
    always_comb begin
        tx_analogreset_o  = (tx_state_q == T_ARST);
        tx_digitalreset_o = (tx_state_q == T_ARST) || (tx_state_q == T_WAIT)
                            || (tx_state_q == T_DRST);
        tx_ready_o        = (tx_state_q == T_READY);
    end

    // RX output decode from the state register.
    always_comb begin
        rx_analogreset_o  = (rx_state_q == R_ARST);
        rx_digitalreset_o = (rx_state_q == R_ARST) || (rx_state_q == R_WAIT);
        rx_ready_o        = (rx_state_q == R_READY);
    end

endmodule

// File: rtl/eth_xcvr_reset_seq.sv
// Quad transceiver reset sequencer: one independent TX/RX sequencer per
// channel, with the shared PLL status fanned out to every channel.
module eth_xcvr_reset_seq
    import eth_xcvr_reset_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int ANALOG_CYCLES  = 100,
    parameter int DIGITAL_CYCLES = 100,
    parameter int LOCK_CYCLES    = 1000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                pll_cal_busy,
    input  logic [CHANNELS-1:0] tx_cal_busy,
    input  logic [CHANNELS-1:0] rx_cal_busy,
    input  logic [CHANNELS-1:0] tx_analogreset_stat,
    input  logic [CHANNELS-1:0] tx_digitalreset_stat,
    input  logic [CHANNELS-1:0] rx_analogreset_stat,
    input  logic [CHANNELS-1:0] rx_digitalreset_stat,
    input  logic [CHANNELS-1:0] rx_is_lockedtodata,
    input  logic [CHANNELS-1:0] rx_restart,
    output logic [CHANNELS-1:0] tx_analogreset,
    output logic [CHANNELS-1:0] tx_digitalreset,
    output logic [CHANNELS-1:0] rx_analogreset,
    output logic [CHANNELS-1:0] rx_digitalreset,
    output logic [CHANNELS-1:0] tx_ready,
    output logic [CHANNELS-1:0] rx_ready
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        eth_xcvr_reset_chan #(
            .ANALOG_CYCLES  (ANALOG_CYCLES),
            .DIGITAL_CYCLES (DIGITAL_CYCLES),
            .LOCK_CYCLES    (LOCK_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_chan (
            .clk                    (clk),
            .rst_n                  (rst_n),
            .pll_locked_i           (pll_locked),
            .pll_cal_busy_i         (pll_cal_busy),
            .tx_cal_busy_i          (tx_cal_busy[ch]),
            .rx_cal_busy_i          (rx_cal_busy[ch]),
            .tx_analogreset_stat_i  (tx_analogreset_stat[ch]),
            .tx_digitalreset_stat_i (tx_digitalreset_stat[ch]),
            .rx_analogreset_stat_i  (rx_analogreset_stat[ch]),
            .rx_digitalreset_stat_i (rx_digitalreset_stat[ch]),
            .rx_is_lockedtodata_i   (rx_is_lockedtodata[ch]),
            .rx_restart_i           (rx_restart[ch]),
            .tx_analogreset_o       (tx_analogreset[ch]),
            .tx_digitalreset_o      (tx_digitalreset[ch]),
            .rx_analogreset_o       (rx_analogreset[ch]),
            .rx_digitalreset_o      (rx_digitalreset[ch]),
            .tx_ready_o             (tx_ready[ch]),
            .rx_ready_o             (rx_ready[ch])
        );
    end

endmodule

// File: doc/eth_xcvr_reset_seq.md
# eth_xcvr_reset_seq

Per-channel transceiver reset sequencer for a quad of 10GBASE-R transceiver channels sharing one TX PLL. It sits between the shared PLL and the per-channel transceiver/PHY wrappers, where the vendor reset-controller IP would otherwise sit. It drives TX/RX analog and digital resets from PLL, calibration, CDR-lock and reset-status feedback. It also supports per-channel RX restart requests from the PCS, such as on high BER.

## Interface
- `CHANNELS`, default 4: number of channels; independent TX and RX FSM per channel.
- `ANALOG_CYCLES`, default 100: minimum clk cycles that analog reset is held asserted.
- `DIGITAL_CYCLES`, default 100: minimum clk cycles that digital reset is held after its release condition becomes true.
- `LOCK_CYCLES`, default 1000: consecutive cycles `rx_is_lockedtodata` must be high before RX digital release.
- `CNT_WIDTH`, default 16: timer width; must hold the largest cycle parameter.

Ports:
- `clk` in 1: control clock (xcvr_ctrl_clk domain); all inputs are synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: shared TX PLL locked.
- `pll_cal_busy` in 1: shared PLL calibrating.
- `tx_cal_busy`, `rx_cal_busy` in CHANNELS: per-channel calibration busy.
- `tx_analogreset_stat`, `tx_digitalreset_stat`, `rx_analogreset_stat`, `rx_digitalreset_stat` in CHANNELS: reset acknowledge from the transceiver.
- `rx_is_lockedtodata` in CHANNELS: CDR locked to data.
- `rx_restart` in CHANNELS: one-cycle pulse; requests a full RX reset of that channel.
- `tx_analogreset`, `tx_digitalreset`, `rx_analogreset`, `rx_digitalreset` out CHANNELS: reset drives, active high.
- `tx_ready`, `rx_ready` out CHANNELS: channel direction operational.

## Operation
TX FSM, per channel:
- **T_ARST**: assert analog and digital reset. Leave when the timer reaches `ANALOG_CYCLES` and `tx_analogreset_stat` is high.
- **T_WAIT**: release analog; digital stays asserted. Wait for `pll_locked`, `!pll_cal_busy`, `!tx_cal_busy` and `!tx_analogreset_stat` all true.
- **T_DRST**: digital stays asserted. Count `DIGITAL_CYCLES`; any failing T_WAIT condition returns to T_WAIT with the timer cleared.
- **T_REL**: release digital. Wait for `tx_digitalreset_stat` low, then go to T_READY.
- **T_READY**: `tx_ready`=1. Loss of `pll_locked` goes to T_WAIT and asserts digital reset.

RX FSM, per channel:
- **R_ARST**: assert analog and digital reset; same exit condition as T_ARST, using `rx_analogreset_stat`.
- **R_WAIT**: release analog. Count consecutive cycles with `rx_is_lockedtodata` high, `!rx_cal_busy` and `!rx_analogreset_stat`. Any failing cycle clears the count. Exit at `LOCK_CYCLES`.
- **R_REL**: release digital. Wait for `rx_digitalreset_stat` low, then go to R_READY.
- **R_READY**: `rx_ready`=1. Loss of `rx_is_lockedtodata` asserts digital reset and goes to R_WAIT.
- `rx_restart` in any RX state goes to R_ARST with the timer cleared; it takes priority over every other transition.

Common rules:
- Timers saturate at all-ones and never wrap.
- One timer per FSM, cleared on every state entry.
- Channels are fully independent apart from the shared PLL inputs. PLL loss pulls every READY TX channel back in the same cycle.

## Timing
- All outputs are registered and decoded from the state register; the state changes one cycle after the qualifying input.
- While `rst_n`=0, and immediately after it is released: all reset outputs are 1, all ready outputs are 0, and the FSMs are in T_ARST/R_ARST. Assertion of `rst_n` mid-sequence does the same, asynchronously.
- Minimum TX bring-up, with every condition already true: (`ANALOG_CYCLES`+1) + 1 + `DIGITAL_CYCLES` + 1 cycles to `tx_ready`. RX bring-up is analogous, using `LOCK_CYCLES`.
- Simultaneous events: `rx_restart` outranks lock loss. Lock loss in the same cycle as the R_REL exit goes to R_WAIT, not R_READY.
- An analog-reset stat that never acknowledges holds the FSM in the ARST state indefinitely; no timeout.

## Structure
- A shared package `eth_xcvr_reset_pkg` holds the TX and RX state encodings (localparams, 3-bit).
- One sub-module is natural: `eth_xcvr_reset_chan`, containing a single channel's TX+RX FSMs and timers. The top instantiates it CHANNELS times via generate and fans out the PLL inputs.

## Test plan
- **Basic bring-up.** Stimulus: release `rst_n`; `pll_locked`=1; cal_busy=0; stats follow resets after 3 cycles; `rx_is_lockedtodata`=1. Required: analog resets drop at cycle ≥100; `tx_ready` rises ≥201 cycles after reset; `rx_ready` after ≥1100.
- **Late PLL lock.** Stimulus: `pll_locked` rises at cycle 500. Required: `tx_digitalreset` stays 1 until ≥600; no `tx_ready` before that.
- **CDR glitch.** Stimulus: `rx_is_lockedtodata` drops for one cycle at lock count 900. Required: counter restarts; `rx_ready` is delayed by ≥1000 cycles from the glitch.
- **Lock loss in READY.** Stimulus: drop `rx_is_lockedtodata` on channel 2 only. Required: `rx_digitalreset[2]`=1 and `rx_ready[2]`=0 next cycle; channels 0/1/3 are unaffected.
- **PLL loss.** Stimulus: `pll_locked`=0 for 10 cycles with all channels READY. Required: all `tx_ready`=0 and `tx_digitalreset`=4'hF next cycle; recovery after `DIGITAL_CYCLES`.
- **Restart plus async reset.** Stimulus: `rx_restart[1]` pulse during R_READY. Required: `rx_analogreset[1]`=1 for ≥100 cycles. Then assert `rst_n`=0 mid-R_WAIT. Required: all outputs return to their reset values without waiting for a clock edge.
